// File: rtl/pdm_serializer.sv
// PDM serializer: buffers 16-bit words and shifts them out MSB first
// against a divided bit clock, filling gaps with a silence word.
module pdm_serializer #(
    parameter int          CLK_DIV    = 100,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] IDLE_WORD  = 16'hAAAA
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        pdm_clk_o,
    output logic        pdm_data_o,
    output logic        done,
    output logic        underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [3:0]    bit_cnt;
    logic [15:0]   sreg;
    logic          from_fifo;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          strobe;
    logic          boundary;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign data_ready = !full;
    assign push       = data_valid && !full;

    assign strobe   = enable && (div_cnt == DIV_LAST) && (state != IDLE);
    assign boundary = strobe && ((state == LOAD) || (bit_cnt == 4'd15));
    // empty is registered, so a word written on this edge is never popped now
    assign pop      = boundary && !empty;

    always_comb begin
        div_nxt = '0;
        if (enable && (div_cnt != DIV_LAST)) begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            from_fifo  <= 1'b0;
            pdm_clk_o  <= 1'b0;
            pdm_data_o <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            pdm_clk_o <= (div_nxt >= DIV_HALF);
            done      <= 1'b0;
            if (!enable) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                sreg       <= '0;
                from_fifo  <= 1'b0;
                pdm_data_o <= 1'b0;
                underrun   <= 1'b0;
            end else begin
                case (state)
                    IDLE:    state <= LOAD;
                    LOAD:    if (strobe) state <= SHIFT;
                    SHIFT:   state <= SHIFT;
                    default: state <= IDLE;
                endcase
                if (boundary) begin
                    done      <= (state == SHIFT) && from_fifo;
                    from_fifo <= !empty;
                    bit_cnt   <= '0;
                    if (!empty) begin
                        sreg       <= mem[rd_ptr];
                        pdm_data_o <= mem[rd_ptr][15];
                    end else begin
                        sreg       <= IDLE_WORD;
                        pdm_data_o <= IDLE_WORD[15];
                        underrun   <= 1'b1;
                    end
                end else if (strobe) begin
                    sreg       <= sreg << 1;
                    pdm_data_o <= sreg[14];
                    bit_cnt    <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_serializer.sv
// Bench for pdm_serializer: queue/strobe-count model checked every cycle
// plus directed scenarios with literal bit-stream expectations.
module tb_pdm_serializer;

    localparam int DIV = 4;
    localparam int FD  = 4;
    localparam logic [15:0] IDLEW = 16'hAAAA;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        pdm_clk_o;
    logic        pdm_data_o;
    logic        done;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    bit live = 1'b0;

    pdm_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(FD), .IDLE_WORD(IDLEW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .pdm_clk_o(pdm_clk_o),
        .pdm_data_o(pdm_data_o),
        .done(done),
        .underrun(underrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: n enabled edges since enable rose; every DIV-th edge is a strobe,
    // every 16th strobe (starting with the first) starts a new word.
    int unsigned n;
    int          pre_n;
    int          s;
    int          idx;
    logic [15:0] q[$];
    logic [15:0] cur;
    bit          cur_fifo;
    logic        m_clk;
    logic        m_data;
    logic        m_done;
    logic        m_unr;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            n = 0; cur = 0; cur_fifo = 0;
            m_clk = 0; m_data = 0; m_done = 0; m_unr = 0;
        end else begin
            pre_n = q.size();
            m_done = 0;
            if (!enable) begin
                n = 0; cur_fifo = 0;
                m_clk = 0; m_data = 0; m_unr = 0;
            end else begin
                n++;
                if (n % DIV == 0) begin
                    s = n / DIV;
                    idx = (s - 1) % 16;
                    if (idx == 0) begin
                        m_done = (s > 1) && cur_fifo;
                        if (pre_n > 0) begin
                            cur = q.pop_front();
                            cur_fifo = 1;
                        end else begin
                            cur = IDLEW;
                            cur_fifo = 0;
                            m_unr = 1;
                        end
                    end
                    m_data = cur[15 - idx];
                end
                m_clk = (n % DIV) >= DIV / 2;
            end
            if (data_valid && pre_n < FD) q.push_back(data_in);
        end
    end

    always @(posedge clock) begin
        #1;
        if (live && reset_n) begin
            chk("pdm_clk_o", pdm_clk_o, m_clk);
            chk("pdm_data_o", pdm_data_o, m_data);
            chk("done", done, m_done);
            chk("underrun", underrun, m_unr);
            chk("data_ready", data_ready, q.size() < FD);
        end
    end

    // Watch n edges, shifting in the output bit at every strobe edge.
    task automatic run(input int nedges, output logic [127:0] bits,
                       output int dones, output int highs);
        bits = '0; dones = 0; highs = 0;
        for (int e = 1; e <= nedges; e++) begin
            @(posedge clock);
            #2;
            if (e % DIV == 0) bits = {bits[126:0], pdm_data_o};
            dones += int'(done);
            highs += int'(pdm_clk_o);
        end
    endtask

    logic [127:0] bits;
    int dones;
    int highs;
    bit acc;

    initial begin
        reset_n = 0; enable = 0; data_valid = 0; data_in = 0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ready", data_ready, 1);
        chk("rst_clk", pdm_clk_o, 0);
        chk("rst_data", pdm_data_o, 0);
        chk("rst_done", done, 0);
        chk("rst_unr", underrun, 0);
        @(negedge clock);
        reset_n = 1;
        live = 1;

        // single word A5C3
        @(negedge clock); data_in = 16'hA5C3; data_valid = 1;
        @(negedge clock); data_valid = 0; enable = 1;
        run(68, bits, dones, highs);
        chk("a5c3_bits", bits[16:1], 16'hA5C3);
        chk("a5c3_fill", bits[0], 1);
        chk("a5c3_dones", dones, 1);
        chk("a5c3_clk_high", highs, 34);
        chk("a5c3_unr", underrun, 1);

        // five words back-to-back, fifth stalls until first pop
        @(negedge clock); enable = 0;
        @(negedge clock); data_in = 16'h1234; data_valid = 1;
        @(negedge clock); data_in = 16'h8001;
        @(negedge clock); data_in = 16'hFFFF;
        @(negedge clock); data_in = 16'h0000;
        @(negedge clock); data_in = 16'hC0DE;
        #1 chk("full_ready", data_ready, 0);
        repeat (2) @(negedge clock);
        enable = 1;
        acc = 0;
        fork
            run(324, bits, dones, highs);
            begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clock);
                    if (data_ready) begin
                        acc = 1;
                        @(negedge clock);
                        data_valid = 0;
                        break;
                    end
                end
                if (!acc) begin
                    data_valid = 0;
                    chk("w5_accept_timeout", 0, 1);
                end
            end
        join
        chk("five_bits", bits[80:1],
            {16'h1234, 16'h8001, 16'hFFFF, 16'h0000, 16'hC0DE});
        chk("five_dones", dones, 5);

        // underrun with empty FIFO, then a word written mid-filler
        @(negedge clock); enable = 0;
        @(negedge clock); enable = 1;
        run(36, bits, dones, highs);
        chk("fill_bits", bits[8:0], 9'b101010101);
        chk("fill_unr", underrun, 1);
        chk("fill_dones", dones, 0);
        fork
            run(96, bits, dones, highs);
            begin
                @(negedge clock); data_in = 16'h0F0F; data_valid = 1;
                @(negedge clock); data_valid = 0;
            end
        join
        chk("late_bits", bits[23:0], {7'b0101010, 16'h0F0F, 1'b1});
        chk("late_dones", dones, 1);
        chk("late_unr", underrun, 1);

        // enable dropped mid-word
        @(negedge clock); enable = 0;
        @(negedge clock); data_in = 16'hFFFF; data_valid = 1;
        @(negedge clock); data_in = 16'h0001;
        @(negedge clock); data_valid = 0; enable = 1;
        run(34, bits, dones, highs);
        chk("drop_bit7", pdm_data_o, 1);
        chk("drop_dones", dones, 0);
        @(negedge clock); enable = 0;
        @(posedge clock); #2;
        chk("drop_clk", pdm_clk_o, 0);
        chk("drop_data", pdm_data_o, 0);
        chk("drop_done", done, 0);
        chk("drop_unr", underrun, 0);
        @(negedge clock); enable = 1;
        run(64, bits, dones, highs);
        chk("reen_bits", bits[15:0], 16'h0001);
        chk("reen_unr", underrun, 0);
        chk("reen_dones", dones, 0);
        run(4, bits, dones, highs);
        chk("reen_done", dones, 1);
        chk("reen_unr2", underrun, 1);

        // asynchronous reset mid-word
        @(negedge clock); enable = 0;
        @(negedge clock); data_in = 16'hFFFF; data_valid = 1;
        @(negedge clock); data_in = 16'h1111;
        @(negedge clock); data_in = 16'h2222;
        @(negedge clock); data_valid = 0; enable = 1;
        run(22, bits, dones, highs);
        chk("pre_rst_clk", pdm_clk_o, 1);
        chk("pre_rst_data", pdm_data_o, 1);
        @(negedge clock);
        #1 reset_n = 0;
        #1;
        chk("arst_clk", pdm_clk_o, 0);
        chk("arst_data", pdm_data_o, 0);
        chk("arst_done", done, 0);
        chk("arst_unr", underrun, 0);
        chk("arst_ready", data_ready, 1);
        #2 reset_n = 1;
        run(8, bits, dones, highs);
        chk("post_rst_bits", bits[1:0], 2'b10);
        chk("post_rst_unr", underrun, 1);
        chk("post_rst_dones", dones, 0);

        // write into empty FIFO on the boundary strobe edge
        @(negedge clock); enable = 0;
        @(negedge clock); enable = 1;
        fork
            run(132, bits, dones, highs);
            begin
                repeat (3) @(negedge clock);
                data_in = 16'h8421; data_valid = 1;
                @(negedge clock); data_valid = 0;
            end
        join
        chk("coinc_bits", bits[32:0], {16'hAAAA, 16'h8421, 1'b1});
        chk("coinc_dones", dones, 1);
        chk("coinc_unr", underrun, 1);

        @(negedge clock);
        live = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
